m_demux_scan: RTL and testbench

- Parametrised, registered successor to the combinational 1-to-N demux.
- Routes a WORD-wide input stream with a valid/ready handshake to one of CH output channels. Each output channel has a 1-deep holding register.
- Two routing modes:
  - Manual: the destination comes from the select port.
  - Scan: an internal pointer rotates through the channels at a programmable tick rate, using the same ratio-load semantics as the clock divider.
- Sits between the serial/parallel front end and per-channel consumers on the 16 MHz clk domain.

---
 rtl/m_demux_scan_pkg.sv | 15 +
 rtl/m_demux_scan_if.sv | 24 ++
 rtl/m_scan_ptr.sv | 55 +++++
 rtl/m_demux_scan.sv | 78 +++++++
 tb/tb_m_demux_scan.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/m_demux_scan_pkg.sv
// Shared defaults and encodings for the registered scan demux.
package m_mpu_pkg;

  localparam int WORD_DEF  = 8;
  localparam int CH_DEF    = 4;
  localparam int SEL_W_DEF = 2;
  localparam int DIV_W_DEF = 4;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  localparam logic [0:0] ST_LOAD = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/m_demux_scan_if.sv
// Input stream plus per-channel output stream of the scan demux.
interface m_demux_scan_if #(
  parameter int WORD = 8,
  parameter int CH   = 4
) ();

  logic              i_valid;
  logic [WORD-1:0]   i_data;
  logic              i_ready;
  logic [CH*WORD-1:0] o_data;
  logic [CH-1:0]     o_valid;
  logic [CH-1:0]     o_ready;

  modport master (
    output i_valid, i_data, o_ready,
    input  i_ready, o_data, o_valid
  );

  modport slave (
    input  i_valid, i_data, o_ready,
    output i_ready, o_data, o_valid
  );

endinterface

// File: rtl/m_scan_ptr.sv
// Scan pointer: programmable dwell counter driving a pointer that wraps at CH-1.
module m_scan_ptr
  import m_mpu_pkg::*;
#(
  parameter int CH    = CH_DEF,
  parameter int SEL_W = SEL_W_DEF,
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mode,
  input  logic             ratio_setting,
  input  logic [DIV_W-1:0] divide_ratio,
  output logic [SEL_W-1:0] scan_ptr
);

  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CH - 1);

  logic [0:0]       st_q;
  logic [DIV_W-1:0] ratio_q;
  logic [DIV_W-1:0] tick_q;
  logic [SEL_W-1:0] ptr_q;

  function automatic logic [DIV_W-1:0] clamp_ratio(input logic [DIV_W-1:0] r);
    return (r == '0) ? DIV_W'(1) : r;
  endfunction

  // The LOAD->RUN cycle already counts, so the first channel dwells exactly ratio cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q    <= ST_RUN;
      ratio_q <= DIV_W'(1);
      tick_q  <= '0;
      ptr_q   <= '0;
    end else if (ratio_setting) begin
      st_q    <= ST_LOAD;
      ratio_q <= clamp_ratio(divide_ratio);
      tick_q  <= '0;
      ptr_q   <= '0;
    end else begin
      if (st_q == ST_LOAD) st_q <= ST_RUN;
      if (mode == MODE_SCAN) begin
        if (tick_q == ratio_q - DIV_W'(1)) begin
          tick_q <= '0;
          ptr_q  <= (ptr_q == LAST_CH) ? '0 : ptr_q + SEL_W'(1);
        end else begin
          tick_q <= tick_q + DIV_W'(1);
        end
      end
    end
  end

  assign scan_ptr = ptr_q;

endmodule

// File: rtl/m_demux_scan.sv
// Registered 1-to-CH demux with manual select or rotating scan destination.
module m_demux_scan
  import m_mpu_pkg::*;
#(
  parameter int WORD  = WORD_DEF,
  parameter int CH    = CH_DEF,
  parameter int SEL_W = SEL_W_DEF,
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mode,
  input  logic [SEL_W-1:0] select,
  input  logic             ratio_setting,
  input  logic [DIV_W-1:0] divide_ratio,
  m_demux_scan_if.slave    bus,
  output logic [SEL_W-1:0] cur_sel,
  output logic             sel_err
);

  localparam logic [SEL_W:0] CH_L = (SEL_W + 1)'(CH);

  logic [SEL_W-1:0] scan_ptr;
  logic             in_range;
  logic             accept;
  logic [CH-1:0]    hit;
  logic [CH-1:0]    room;
  logic             vld_p1  [CH];
  logic [WORD-1:0]  data_p1 [CH];
  logic             sel_err_q;

  m_scan_ptr #(
    .CH    (CH),
    .SEL_W (SEL_W),
    .DIV_W (DIV_W)
  ) u_scan_ptr (
    .clk           (clk),
    .reset         (reset),
    .mode          (mode),
    .ratio_setting (ratio_setting),
    .divide_ratio  (divide_ratio),
    .scan_ptr      (scan_ptr)
  );

  assign cur_sel     = (mode == MODE_SCAN) ? scan_ptr : select;
  assign in_range    = {1'b0, cur_sel} < CH_L;
  assign bus.i_ready = ~reset & |(hit & room);
  assign accept      = bus.i_valid & bus.i_ready;

  // Stage p1: one holding register per channel; a draining slot may refill in the same cycle.
  for (genvar k = 0; k < CH; k++) begin : g_ch
    assign hit[k]  = in_range & (cur_sel == SEL_W'(k));
    assign room[k] = ~vld_p1[k] | bus.o_ready[k];

    always_ff @(posedge clk) begin
      if (reset) begin
        vld_p1[k]  <= 1'b0;
        data_p1[k] <= '0;
      end else if (accept & hit[k]) begin
        vld_p1[k]  <= 1'b1;
        data_p1[k] <= bus.i_data;
      end else if (bus.o_ready[k]) begin
        vld_p1[k]  <= 1'b0;
      end
    end

    assign bus.o_valid[k]               = vld_p1[k];
    assign bus.o_data[k*WORD +: WORD]   = data_p1[k];
  end

  always_ff @(posedge clk) begin
    if (reset)                      sel_err_q <= 1'b0;
    else if (bus.i_valid & ~in_range) sel_err_q <= 1'b1;
  end

  assign sel_err = sel_err_q;

endmodule

// File: tb/tb_m_demux_scan.sv
// Scoreboard bench for m_demux_scan: a 4-channel instance plus a 3-channel one for range errors.
module tb_m_demux_scan;

  logic       clk = 1'b0;
  logic       reset;
  logic       mode;
  logic [1:0] select;
  logic       ratio_setting;
  logic [3:0] divide_ratio;
  logic [1:0] cur_sel4, cur_sel3;
  logic       sel_err4, sel_err3;

  always #31 clk = ~clk;

  m_demux_scan_if #(.WORD(8), .CH(4)) bus4 ();
  m_demux_scan_if #(.WORD(8), .CH(3)) bus3 ();

  m_demux_scan #(.WORD(8), .CH(4), .SEL_W(2), .DIV_W(4)) dut (
    .clk(clk), .reset(reset), .mode(mode), .select(select),
    .ratio_setting(ratio_setting), .divide_ratio(divide_ratio),
    .bus(bus4.slave), .cur_sel(cur_sel4), .sel_err(sel_err4)
  );

  m_demux_scan #(.WORD(8), .CH(3), .SEL_W(2), .DIV_W(4)) dut3 (
    .clk(clk), .reset(reset), .mode(mode), .select(select),
    .ratio_setting(ratio_setting), .divide_ratio(divide_ratio),
    .bus(bus3.slave), .cur_sel(cur_sel3), .sel_err(sel_err3)
  );

  int n_checks = 0;
  int n_errs   = 0;
  logic [7:0] sbq [4][$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus4.i_valid = 1'b1;
    #1;
    chk("rst_i_ready", 32'(bus4.i_ready), 0);
    cyc();
    for (int k = 0; k < 4; k++) sbq[k].delete();
    reset = 1'b0;
    bus4.i_valid = 1'b0;
  endtask

  task automatic offer(input int ch, input logic [7:0] d, input logic exp_rdy);
    bus4.i_valid = 1'b1;
    bus4.i_data  = d;
    #1;
    chk("i_ready", 32'(bus4.i_ready), 32'(exp_rdy));
    if (exp_rdy) sbq[ch].push_back(d);
    cyc();
    bus4.i_valid = 1'b0;
  endtask

  // Drained words are popped from the per-channel expectation queues.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      for (int k = 0; k < 4; k++) begin
        if (bus4.o_valid[k] && bus4.o_ready[k]) begin
          if (sbq[k].size() == 0) chk("sb_unexpected", 32'(sbq[k].size()), 1);
          else chk("sb_data", 32'(bus4.o_data[k*8 +: 8]), 32'(sbq[k].pop_front()));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; mode = 1'b0; select = '0; ratio_setting = 1'b0; divide_ratio = '0;
    bus4.i_valid = 1'b0; bus4.i_data = '0; bus4.o_ready = '0;
    bus3.i_valid = 1'b0; bus3.i_data = '0; bus3.o_ready = '0;
    do_reset();
    chk("rst_o_valid", 32'(bus4.o_valid), 0);
    chk("rst_o_data", bus4.o_data, 0);
    chk("rst_sel_err", 32'(sel_err3), 0);
    chk("rst_cur_sel", 32'(cur_sel4), 0);

    // Manual routing and back-pressure
    mode = 1'b0; select = 2'd2; bus4.o_ready = 4'b0000;
    offer(2, 8'hA5, 1'b1);
    chk("man_o_valid", 32'(bus4.o_valid), 32'b0100);
    chk("man_o_data", bus4.o_data, 32'h00A5_0000);
    offer(2, 8'h5A, 1'b0);
    chk("bp_o_data", bus4.o_data, 32'h00A5_0000);

    // Pass-through on a draining channel
    select = 2'd1;
    offer(1, 8'h11, 1'b1);
    chk("pt_fill", 32'(bus4.o_valid), 32'b0110);
    bus4.o_ready = 4'b0010;
    offer(1, 8'h22, 1'b1);
    chk("pt_o_valid", 32'(bus4.o_valid), 32'b0110);
    chk("pt_o_data", 32'(bus4.o_data[15:8]), 32'h22);
    bus4.o_ready = 4'hF;
    cyc();
    chk("drain_o_valid", 32'(bus4.o_valid), 0);
    chk("drain_hold", bus4.o_data, 32'h00A5_2200);

    // Scan dwell of 4, then ratio 0 behaving as 1
    ratio_setting = 1'b1; divide_ratio = 4'd4;
    cyc();
    ratio_setting = 1'b0; mode = 1'b1;
    for (int i = 0; i < 17; i++) begin
      #1;
      chk("scan_r4", 32'(cur_sel4), 32'((i / 4) % 4));
      cyc();
    end
    ratio_setting = 1'b1; divide_ratio = 4'd0;
    cyc();
    ratio_setting = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("scan_r0", 32'(cur_sel4), 32'(i % 4));
      cyc();
    end

    // Scan traffic: one accept per cycle, round-robin over channels
    ratio_setting = 1'b1; divide_ratio = 4'd1;
    cyc();
    ratio_setting = 1'b0;
    for (int i = 0; i < 12; i++) begin
      bus4.i_valid = 1'b1;
      bus4.i_data  = 8'(i);
      #1;
      chk("st_cur_sel", 32'(cur_sel4), 32'(i % 4));
      chk("st_wrap3", 32'(cur_sel3), 32'(i % 3));
      chk("st_i_ready", 32'(bus4.i_ready), 1);
      sbq[i % 4].push_back(8'(i));
      cyc();
    end
    bus4.i_valid = 1'b0; mode = 1'b0;
    cyc();
    cyc();
    for (int k = 0; k < 4; k++) chk("sb_left", 32'(sbq[k].size()), 0);

    // Out-of-range destination on the 3-channel instance
    chk("oor_pre", 32'(sel_err3), 0);
    select = 2'd3; bus3.i_valid = 1'b1; bus3.i_data = 8'h77;
    #1;
    chk("oor_i_ready", 32'(bus3.i_ready), 0);
    cyc();
    chk("oor_sel_err", 32'(sel_err3), 1);
    chk("oor_o_valid", 32'(bus3.o_valid), 0);
    select = 2'd0; bus3.i_valid = 1'b0;
    cyc();
    chk("oor_sticky", 32'(sel_err3), 1);

    // Reset with every channel full and the scan pointer at 2
    bus4.o_ready = 4'h0; mode = 1'b0;
    for (int k = 0; k < 4; k++) begin
      select = 2'(k);
      offer(k, 8'hC0 + 8'(k), 1'b1);
    end
    chk("full_o_valid", 32'(bus4.o_valid), 32'hF);
    ratio_setting = 1'b1; divide_ratio = 4'd1;
    cyc();
    ratio_setting = 1'b0; mode = 1'b1;
    cyc();
    cyc();
    #1;
    chk("pre_rst_ptr", 32'(cur_sel4), 2);
    do_reset();
    chk("mr_o_valid", 32'(bus4.o_valid), 0);
    chk("mr_o_data", bus4.o_data, 0);
    chk("mr_cur_sel", 32'(cur_sel4), 0);
    chk("mr_sel_err", 32'(sel_err3), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
